// File: rtl/bcd_seg_pkg.sv
// Shared constants for the multiplexed sign+BCD 7-segment driver.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package bcd_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] SIGN_NEG = 4'd5;
    localparam logic [3:0] SIGN_POS = 4'd0;

endpackage

// File: rtl/bcd_seg_scan_seg_decode.sv
// Combinational BCD nibble to active-low segment pattern.
// Non-decimal nibbles render as 'E' so corrupt data is visible on the display.
module seg_decode
    import bcd_seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_E;
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_E;
        endcase
    end

endmodule

// File: rtl/bcd_seg_scan.sv
// Five-digit common-anode scan driver for a sign+BCD word, with snapshot
// capture at frame wrap, anti-ghosting blank interval and leading-zero suppression.
module bcd_seg_scan
    import bcd_seg_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [19:0] bcd,
    input  logic        load,
    input  logic        blank_en,
    output logic [4:0]  an,
    output logic [6:0]  seg,
    output logic        frame_tick
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] presc;
    logic [2:0]    idx;
    logic [19:0]   shadow;
    logic          pending;
    logic          wrap_d;

    logic          terminal;
    logic          wrap;
    logic [3:0]    mag_nib;
    logic [6:0]    mag_seg;
    logic [6:0]    sign_seg;
    logic [6:0]    slot_seg;
    logic [4:0]    slot_an;
    logic          thou_z, hund_z, tens_z;

    assign terminal = (presc == PW'(SCAN_DIV - 1));
    assign wrap     = terminal && (idx == 3'd4);

    assign thou_z = (shadow[15:12] == 4'd0);
    assign hund_z = (shadow[11:8]  == 4'd0);
    assign tens_z = (shadow[7:4]   == 4'd0);

    always_comb begin
        mag_nib = shadow[3:0];
        case (idx)
            3'd1:    mag_nib = shadow[7:4];
            3'd2:    mag_nib = shadow[11:8];
            3'd3:    mag_nib = shadow[15:12];
            default: mag_nib = shadow[3:0];
        endcase
    end

    seg_decode u_dec (
        .nib (mag_nib),
        .seg (mag_seg)
    );

    // A negative zero is shown blank rather than "-0".
    always_comb begin
        sign_seg = SEG_E;
        if (shadow[19:16] == SIGN_NEG)
            sign_seg = (shadow[15:0] != 16'd0) ? SEG_MINUS : SEG_BLANK;
        else if (shadow[19:16] == SIGN_POS)
            sign_seg = SEG_BLANK;
    end

    always_comb begin
        slot_seg = SEG_BLANK;
        case (idx)
            3'd0: slot_seg = mag_seg;
            3'd1: slot_seg = (blank_en && thou_z && hund_z && tens_z) ? SEG_BLANK : mag_seg;
            3'd2: slot_seg = (blank_en && thou_z && hund_z) ? SEG_BLANK : mag_seg;
            3'd3: slot_seg = (blank_en && thou_z) ? SEG_BLANK : mag_seg;
            3'd4: slot_seg = sign_seg;
            default: slot_seg = SEG_BLANK;
        endcase
    end

    assign slot_an = (presc < PW'(BLANK_CYC)) ? 5'b11111 : ~(5'b00001 << idx);

    // Outputs are registered from the current scan position, so an/seg/frame_tick
    // lag idx/prescaler by one cycle and frame_tick lines up with slot 0's first cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc      <= '0;
            idx        <= 3'd0;
            shadow     <= 20'h00000;
            pending    <= 1'b0;
            wrap_d     <= 1'b0;
            frame_tick <= 1'b0;
            an         <= 5'b11111;
            seg        <= SEG_BLANK;
        end else begin
            presc      <= terminal ? '0 : presc + PW'(1);
            if (terminal)
                idx <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
            wrap_d     <= wrap;
            frame_tick <= wrap_d;
            an         <= slot_an;
            seg        <= slot_seg;
            if (wrap) begin
                if (pending || load)
                    shadow <= bcd;
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Directed bench for bcd_seg_scan with an 8-cycle slot and 2-cycle blank interval.
module tb_bcd_seg_scan;

    localparam int SD = 8;
    localparam int BC = 2;

    logic        clk;
    logic        rst_n;
    logic [19:0] bcd;
    logic        load;
    logic        blank_en;
    logic [4:0]  an;
    logic [6:0]  seg;
    logic        frame_tick;

    int n_cmp;
    int n_bad;

    bcd_seg_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bcd        (bcd),
        .load       (load),
        .blank_en   (blank_en),
        .an         (an),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [19:0]     bcd;
        logic            be;
        logic [4:0][6:0] exp;   // exp[k] = seg in slot k (0 = units, 4 = sign)
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Returns at the negedge on which frame_tick is seen high.
    task automatic wait_frame_tick();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) return;
        end
        chk("frame_tick_timeout", 32'd0, 32'd1);
    endtask

    // Called on the negedge where frame_tick is high; walks one whole frame.
    task automatic check_frame(input string tag, input logic [4:0][6:0] exp);
        for (int c = 0; c < 5 * SD; c++) begin
            int k;
            int off;
            k   = c / SD;
            off = c % SD;
            if (off == 0) begin
                chk($sformatf("%s s%0d seg_first", tag, k), {25'd0, seg}, {25'd0, exp[k]});
                chk($sformatf("%s s%0d an_blank", tag, k), {27'd0, an}, 32'h1F);
                chk($sformatf("%s s%0d tick", tag, k), {31'd0, frame_tick}, (c == 0) ? 32'd1 : 32'd0);
            end
            if (off == BC) begin
                chk($sformatf("%s s%0d an_on", tag, k), {27'd0, an}, {27'd0, ~(5'b00001 << k)});
            end
            if (off == BC - 1) begin
                chk($sformatf("%s s%0d an_last_blank", tag, k), {27'd0, an}, 32'h1F);
            end
            if (off == SD - 1) begin
                chk($sformatf("%s s%0d seg_last", tag, k), {25'd0, seg}, {25'd0, exp[k]});
                chk($sformatf("%s s%0d an_last", tag, k), {27'd0, an}, {27'd0, ~(5'b00001 << k)});
            end
            if (c == 1)
                chk($sformatf("%s tick_one_cycle", tag), {31'd0, frame_tick}, 32'd0);
            if (c < 5 * SD - 1) @(negedge clk);
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        bcd      = 20'h00000;
        load     = 1'b0;
        blank_en = 1'b1;

        vecs[0] = '{20'h01234, 1'b1, {7'h7F, 7'h79, 7'h24, 7'h30, 7'h19}};
        vecs[1] = '{20'h50007, 1'b1, {7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h78}};
        vecs[2] = '{20'h50007, 1'b0, {7'h3F, 7'h40, 7'h40, 7'h40, 7'h78}};
        vecs[3] = '{20'h50000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[4] = '{20'h50000, 1'b0, {7'h7F, 7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[5] = '{20'h00A0C, 1'b1, {7'h7F, 7'h7F, 7'h06, 7'h40, 7'h06}};
        vecs[6] = '{20'h30001, 1'b1, {7'h06, 7'h7F, 7'h7F, 7'h7F, 7'h79}};

        // Power-on reset
        repeat (3) @(negedge clk);
        chk("por an", {27'd0, an}, 32'h1F);
        chk("por seg", {25'd0, seg}, 32'h7F);
        chk("por tick", {31'd0, frame_tick}, 32'd0);
        rst_n = 1'b1;

        // Mid-scan reset with a load pending must drop the load
        repeat (13) @(negedge clk);
        bcd  = 20'h12345;
        load = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst%0d an", i), {27'd0, an}, 32'h1F);
            chk($sformatf("rst%0d seg", i), {25'd0, seg}, 32'h7F);
            chk($sformatf("rst%0d tick", i), {31'd0, frame_tick}, 32'd0);
        end
        rst_n = 1'b1;
        load  = 1'b0;
        wait_frame_tick();
        check_frame("after_rst", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});

        // Table-driven words
        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            bcd      = vecs[v].bcd;
            blank_en = vecs[v].be;
            load     = 1'b1;
            @(negedge clk);
            load = 1'b0;
            wait_frame_tick();
            wait_frame_tick();
            check_frame($sformatf("vec%0d", v), vecs[v].exp);
        end

        // Load in slot 2, bcd changes before the wrap: wrap-time value is shown
        blank_en = 1'b1;
        wait_frame_tick();
        repeat (2 * SD + 1) @(negedge clk);
        bcd  = 20'h00111;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        bcd = 20'h00222;
        wait_frame_tick();
        check_frame("late_change", {7'h7F, 7'h7F, 7'h24, 7'h24, 7'h24});

        // Load asserted only on the wrap cycle is captured in that frame
        wait_frame_tick();
        repeat (5 * SD - 2) @(posedge clk);
        @(negedge clk);
        bcd  = 20'h04321;
        load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        wait_frame_tick();
        check_frame("wrap_load", {7'h7F, 7'h19, 7'h30, 7'h24, 7'h79});

        // bcd change without load leaves the display alone
        bcd = 20'h09999;
        wait_frame_tick();
        wait_frame_tick();
        check_frame("no_load", {7'h7F, 7'h19, 7'h30, 7'h24, 7'h79});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bcd_seg_scan.md
# bcd_seg_scan

Multiplexed 7-segment display driver consuming the 20-bit sign+BCD word produced by the signed-binary-to-BCD converter (sign digit 5 = negative, 0 = positive, then thousands/hundreds/tens/units). It snapshots the word on request, time-multiplexes five common-anode digits with a programmable slot time and an anti-ghosting blank interval, and applies leading-zero suppression. It is the last stage before the board pins.

## Interface
- SCAN_DIV, 50000, clock cycles per digit slot (≥ 4)
- BLANK_CYC, 16, cycles at slot start with all anodes off (1 ≤ BLANK_CYC < SCAN_DIV)
- clk  in  1  system clock
- rst_n  in  1  reset: one clock; reset is synchronous and active-low
- bcd  in  20  {sign[19:16], thou[15:12], hund[11:8], tens[7:4], units[3:0]}
- load  in  1  request capture of bcd; one-cycle pulse or level
- blank_en  in  1  1 = suppress leading zeros
- an  out  5  digit enables, active-low; an[0] = units … an[4] = sign
- seg  out  7  {g,f,e,d,c,b,a}, active-low
- frame_tick  out  1  one-cycle pulse when slot index wraps 4→0

## Operation
- Prescaler counts 0..SCAN_DIV-1; at terminal count slot index idx advances 0→1→2→3→4→0.
- Shadow register holds the displayed word; seg is decoded only from shadow, never from bcd directly.
- load sets pending. At the wrap (idx 4→0), if pending or load is high on that cycle, shadow ← bcd sampled on the wrap cycle and pending clears. Multiple loads within a frame collapse to one capture of the value at the wrap.
- Digit decode, magnitude nibbles: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex); nibble >9 → 'E' = 06.
- Sign slot: nibble 5 with nonzero magnitude → minus 3F; nibble 5 with magnitude 0000 → blank 7F (no "-0"); nibble 0 → 7F; any other value → 06.
- Leading-zero blanking (blank_en=1): thousands blank if 0; hundreds blank if thousands and hundreds are 0; tens blank if thou, hund and tens are 0; units never blanked. Invalid nibbles count as nonzero. blank_en=0: zeros shown as 40. blank_en is sampled live each slot.
- Blanked digit: its an bit still follows the slot schedule, seg = 7F.

## Timing
- Reset values: an=11111, seg=7F, frame_tick=0, prescaler=0, idx=0, shadow=00000, pending=0.
- Slot k occupies SCAN_DIV cycles. During its first BLANK_CYC cycles an=11111; for the remainder an has only bit k low. seg takes the slot-k pattern on the first cycle of the slot and holds it for the whole slot.
- All outputs registered; idx and prescaler change on the same edge, and an/seg reflect them one cycle later.
- First frame after reset displays shadow=00000: units 40, others blank when blank_en=1.
- frame_tick asserts for exactly one cycle, in the cycle after the 4→0 wrap edge, together with the first cycle of slot 0.
- Reset mid-frame: next edge with rst_n low restores all reset values and drops any pending load.

## Structure
- Package bcd_seg_pkg: segment constants SEG_0..SEG_9, SEG_MINUS, SEG_E, SEG_BLANK; sign codes SIGN_NEG=4'd5, SIGN_POS=4'd0.
- One sub-module, seg_decode: combinational nibble → 7-bit active-low pattern including the E fallback. Blanking and sign logic stay in the top.

## Test plan
Run with SCAN_DIV=8, BLANK_CYC=2.
- Reset: rst_n low 3 cycles mid-scan with load pending → an=11111, seg=7F, frame_tick=0; after release, shadow stays 00000 even though load was high.
- bcd=01234, load, blank_en=1 → after next frame_tick, slots 0..4 show seg 19,30,24,79,7F; an shows 11111 for 2 cycles, then single-low for 6 cycles.
- bcd=50007, blank_en=1 → 78,7F,7F,7F,3F. Same word with blank_en=0 → 78,40,40,40,3F.
- bcd=50000 → sign 7F, units 40. bcd=00A0C → units 06, tens 40 (not blanked, since hundreds is invalid), hundreds 06, thousands blank, sign 7F.
- Load pulse in slot 2, then bcd changes before the wrap → the value at the wrap is captured. Load only on the wrap cycle → captured in that frame. bcd change without load → display unchanged.
- Invalid sign bcd=30001 → sign 06, units 79.
